// File: rtl/fix_to_single_pipe.sv
// Three-stage fixed-point to IEEE-754 single-precision converter with valid/ready flow control.
// Optional macro FIX_TO_SINGLE_ROUND_EN selects round-to-nearest-even; undefined truncates toward zero.
module fix_to_single_pipe #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4,
    parameter bit SIGNED      = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      out_data,
    output logic                             out_inexact
);

    localparam int N        = INT_WIDTH + FRACT_WIDTH;
    localparam int LZW      = $clog2(N + 1);
    localparam int EXP_BASE = 127 + INT_WIDTH - 1;

    generate
        if (N < 2 || N > 64 || INT_WIDTH < 0 || FRACT_WIDTH < 0 ||
            INT_WIDTH - 1 > 126 || FRACT_WIDTH > 126) begin : g_param_check
            $error("fix_to_single_pipe: illegal INT_WIDTH/FRACT_WIDTH combination");
        end
    endgenerate

    logic v1_q, v2_q, v3_q;
    logic ready1, ready2, ready3;

    logic           s1_sign_q, s1_sign_d;
    logic [N-1:0]   s1_mag_q,  s1_mag_d;
    logic           s2_sign_q;
    logic [LZW-1:0] s2_lz_q,   s2_lz_d;
    logic [N-1:0]   s2_norm_q, s2_norm_d;
    logic [31:0]    s3_data_q, s3_data_d;
    logic           s3_inexact_q, s3_inexact_d;

    // A stage may load when it is empty or its contents move on this cycle.
    assign ready3    = !v3_q || out_ready;
    assign ready2    = !v2_q || ready3;
    assign ready1    = !v1_q || ready2;
    assign in_ready  = ready1;
    assign out_valid = v3_q;
    assign out_data  = s3_data_q;
    assign out_inexact = s3_inexact_q;

    // Stage 1: sign and absolute value; the N-bit negate maps the most negative code to 2^(N-1).
    always_comb begin
        s1_sign_d = 1'b0;
        s1_mag_d  = in_data;
        if (SIGNED && in_data[N-1]) begin
            s1_sign_d = 1'b1;
            s1_mag_d  = -in_data;
        end
    end

    // Stage 2: leading-zero count; the highest set bit is the last one to win the scan.
    always_comb begin
        s2_lz_d = LZW'(N);
        for (int i = 0; i < N; i++) begin
            if (s1_mag_q[i]) s2_lz_d = LZW'(N - 1 - i);
        end
        s2_norm_d = s1_mag_q << s2_lz_d;
    end

    // Stage 3: the bits below the leading one are padded to 23 mantissa bits plus guard/sticky.
    logic [N+22:0] frac;
    logic [22:0]   mant_w, mant_r;
    logic [7:0]    exp_w, exp_r;
    logic          guard, sticky, is_zero;
`ifdef FIX_TO_SINGLE_ROUND_EN
    logic          round_up;
`endif

    always_comb begin
        frac    = {s2_norm_q[N-2:0], 24'd0};
        mant_w  = frac[N+22 -: 23];
        guard   = frac[N-1];
        sticky  = |frac[N-2:0];
        is_zero = !s2_norm_q[N-1];
        exp_w   = 8'(EXP_BASE) - 8'(s2_lz_q);
`ifdef FIX_TO_SINGLE_ROUND_EN
        // A carry out of an all-ones mantissa clears it and bumps the exponent field.
        round_up       = guard & (sticky | mant_w[0]);
        {exp_r, mant_r} = {exp_w, mant_w} + 31'(round_up);
`else
        {exp_r, mant_r} = {exp_w, mant_w};
`endif
        s3_data_d    = {s2_sign_q, exp_r, mant_r};
        s3_inexact_d = guard | sticky;
        if (is_zero) begin
            s3_data_d    = '0;
            s3_inexact_d = 1'b0;
        end
    end

    // NOTE: only the valid flags and the visible output need reset; upstream data is qualified by valid.
    always_ff @(posedge clk) begin
        if (ready1 && in_valid) begin
            s1_sign_q <= s1_sign_d;
            s1_mag_q  <= s1_mag_d;
        end
        if (ready2 && v1_q) begin
            s2_sign_q <= s1_sign_q;
            s2_lz_q   <= s2_lz_d;
            s2_norm_q <= s2_norm_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
            s3_data_q    <= '0;
            s3_inexact_q <= 1'b0;
        end else begin
            if (ready1) v1_q <= in_valid;
            if (ready2) v2_q <= v1_q;
            if (ready3) v3_q <= v2_q;
            if (ready3 && v2_q) begin
                s3_data_q    <= s3_data_d;
                s3_inexact_q <= s3_inexact_d;
            end
        end
    end

endmodule
